data_sync_launch: RTL and testbench

- Source-domain launcher that sits directly upstream of the destination-domain bus synchronizer (multi-flop enable sync plus pulse-gen mux).
- Accepts words through a valid/ready handshake and drives a registered, stable bus (unsync_bus) plus a level enable (bus_enable).
- bus_enable stays high for HOLD_CYCLES, then low for GAP_CYCLES. This lets the destination see exactly one rising edge per word while the bus does not move.
- Open-loop: there is no acknowledge path. Safe operation depends on the HOLD_CYCLES and GAP_CYCLES values chosen at integration.

---
 rtl/data_sync_pkg.sv | 29 ++
 rtl/launch_cnt.sv | 29 ++
 rtl/data_sync_launch.sv | 129 ++++++++++++
 tb/tb_data_sync_launch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
`timescale 1ns/1ps
// Shared state encoding and integration margins for the source-side bus-sync launcher.
package data_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_t;

  // Destination needs NUM_STAGES plus these many of its clocks per enable phase.
  localparam int HOLD_MARGIN = 2;
  localparam int GAP_MARGIN  = 1;

  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m) + 1;
  endfunction

  function automatic int min_hold_dest_clks(input int num_stages);
    return num_stages + HOLD_MARGIN;
  endfunction

  function automatic int min_gap_dest_clks(input int num_stages);
    return num_stages + GAP_MARGIN;
  endfunction

endpackage

// File: rtl/launch_cnt.sv
`timescale 1ns/1ps
// Loadable down-counter with zero flag; load wins over decrement, saturates at zero.
// Single-cycle update, no backpressure.
module launch_cnt #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/data_sync_launch.sv
`timescale 1ns/1ps
// Drives a frozen bus plus a HOLD-high / GAP-low enable per word for a destination synchronizer.
// Bus and enable appear the cycle after acceptance; one-word pend slot, in_ready = slot empty.
module data_sync_launch
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 busy
);

  localparam int CNT_WIDTH = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);

  state_t                 state, state_nxt;
  logic                   pend_valid;
  logic [BUS_WIDTH-1:0]   pend_data;
  logic                   transfer;
  logic                   cnt_zero, cnt_load, cnt_dec;
  logic [CNT_WIDTH-1:0]   cnt_val;
  logic                   launch, enable_nxt, pend_set, pend_clr;
  logic [BUS_WIDTH-1:0]   launch_data;

  assign in_ready = ~pend_valid;
  assign transfer = in_valid & in_ready;
  assign busy     = (state != IDLE) | pend_valid;

  launch_cnt #(.W(CNT_WIDTH)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt   = state;
    cnt_load    = 1'b0;
    cnt_val     = HOLD_LOAD;
    cnt_dec     = 1'b0;
    launch      = 1'b0;
    launch_data = pend_data;
    enable_nxt  = bus_enable;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    case (state)
      IDLE: begin
        enable_nxt = 1'b0;
        if (transfer) begin
          launch      = 1'b1;
          launch_data = in_data;
          enable_nxt  = 1'b1;
          cnt_load    = 1'b1;
          state_nxt   = HOLD;
        end
      end
      HOLD: begin
        enable_nxt = 1'b1;
        pend_set   = transfer;
        if (cnt_zero) begin
          enable_nxt = 1'b0;
          cnt_load   = 1'b1;
          cnt_val    = GAP_LOAD;
          state_nxt  = GAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        enable_nxt = 1'b0;
        if (!cnt_zero) begin
          cnt_dec  = 1'b1;
          pend_set = transfer;
        end else if (pend_valid) begin
          launch     = 1'b1;
          pend_clr   = 1'b1;
          enable_nxt = 1'b1;
          cnt_load   = 1'b1;
          state_nxt  = HOLD;
        end else if (transfer) begin
          // Pend is empty on the last gap cycle: launch the incoming word directly.
          launch      = 1'b1;
          launch_data = in_data;
          enable_nxt  = 1'b1;
          cnt_load    = 1'b1;
          state_nxt   = HOLD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        enable_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus_enable <= enable_nxt;
      if (launch) unsync_bus <= launch_data;
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_data  <= in_data;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_sync_launch.sv
`timescale 1ns/1ps
// Directed and scoreboarded checks of data_sync_launch with HOLD=4, GAP=3, 8-bit bus.
module tb_data_sync_launch;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] unsync_bus;
  logic       bus_enable;
  logic       busy;

  data_sync_launch #(.BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .unsync_bus (unsync_bus),
    .bus_enable (bus_enable),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural destination: 2-flop enable sync plus rising-edge pulse, clock 13ns.
  logic       dclk = 1'b0;
  logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic       collect = 1'b0;
  logic [7:0] obs[$];

  initial begin
    #3.3;
    forever begin
      dclk = 1'b1; #6.5;
      dclk = 1'b0; #6.5;
    end
  end

  always @(posedge dclk) begin
    if (collect && s2 && !s3) obs.push_back(unsync_bus);
    s3 <= s2;
    s2 <= s1;
    s1 <= bus_enable;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b2b[3];
    logic [7:0] exp_q[$];
    int         rise_t[$];
    logic [7:0] rise_d[$];
    int         idx, stab_bad, sent, cyc;
    logic       rdy, prev_en;
    logic [7:0] prev_bus;

    // Reset state, before any clock edge and then idle after release.
    #1;
    chk("rst_en", 32'(bus_enable), 0);
    chk("rst_bus", 32'(unsync_bus), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    tick; tick;
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("idle_outs", 32'({bus_enable, unsync_bus, in_ready, busy}), 'h2);
    end

    // Single word: high t+1..t+4, low t+5..t+7, idle at t+8.
    in_data = 8'hA5; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("single_en", 32'(bus_enable), 32'(k <= 4));
      chk("single_bus", 32'(unsync_bus), 'hA5);
      chk("single_busy", 32'(busy), 32'(k <= 7));
      tick;
    end

    // Back-to-back words through the pend slot.
    b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33;
    idx = 0; stab_bad = 0;
    prev_en = bus_enable; prev_bus = unsync_bus;
    for (int c = 0; c < 24; c++) begin
      in_valid = (idx < 3);
      in_data  = b2b[(idx < 3) ? idx : 2];
      rdy = in_ready;
      if (c == 2) chk("b2b_rdy_full", 32'(in_ready), 0);
      tick;
      if (in_valid && rdy) idx++;
      if (bus_enable && !prev_en) begin
        rise_t.push_back(c + 1);
        rise_d.push_back(unsync_bus);
      end else if (unsync_bus != prev_bus) begin
        stab_bad++;
      end
      prev_en = bus_enable; prev_bus = unsync_bus;
    end
    in_valid = 1'b0;
    chk("b2b_rises", 32'(rise_t.size()), 3);
    chk("b2b_stable", 32'(stab_bad), 0);
    if (rise_t.size() == 3) begin
      chk("b2b_t0", 32'(rise_t[0]), 1);
      chk("b2b_t1", 32'(rise_t[1]), 8);
      chk("b2b_t2", 32'(rise_t[2]), 15);
      chk("b2b_d0", 32'(rise_d[0]), 'h11);
      chk("b2b_d1", 32'(rise_d[1]), 'h22);
      chk("b2b_d2", 32'(rise_d[2]), 'h33);
    end
    chk("b2b_idle", 32'(busy), 0);

    // Word offered on the final GAP cycle with pend empty takes the bypass.
    in_data = 8'h44; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (6) tick;
    chk("byp_last_gap_en", 32'(bus_enable), 0);
    chk("byp_last_gap_busy", 32'(busy), 1);
    in_data = 8'h55; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("byp_en", 32'(bus_enable), 1);
    chk("byp_bus", 32'(unsync_bus), 'h55);
    chk("byp_rdy", 32'(in_ready), 1);
    tick;
    chk("byp_rdy2", 32'(in_ready), 1);
    chk("byp_en2", 32'(bus_enable), 1);
    repeat (7) tick;
    chk("byp_idle", 32'(busy), 0);
    chk("byp_bus_kept", 32'(unsync_bus), 'h55);

    // Reset during HOLD with a word pending.
    in_data = 8'h66; in_valid = 1'b1;
    tick;
    in_data = 8'h77;
    tick;
    in_valid = 1'b0;
    chk("mid_rdy_before", 32'(in_ready), 0);
    RST = 1'b1;
    #1;
    chk("mid_rst_en", 32'(bus_enable), 0);
    chk("mid_rst_bus", 32'(unsync_bus), 0);
    chk("mid_rst_rdy", 32'(in_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    tick;
    RST = 1'b0;
    tick;
    chk("post_rst_idle", 32'({bus_enable, unsync_bus, busy}), 0);
    in_data = 8'h88; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("post_rst_en", 32'(bus_enable), 1);
    chk("post_rst_bus", 32'(unsync_bus), 'h88);
    repeat (7) tick;
    chk("post_rst_done", 32'({bus_enable, unsync_bus, busy}), 'h110);
    repeat (4) tick;

    // Random traffic against the behavioural destination.
    obs.delete();
    collect = 1'b1;
    sent = 0; cyc = 0;
    while (sent < 200 && cyc < 4000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom_range(0, 255));
      rdy = in_ready;
      tick;
      if (in_valid && rdy) begin
        exp_q.push_back(in_data);
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    while (busy && cyc < 4000) begin
      tick;
      cyc++;
    end
    repeat (10) tick;
    collect = 1'b0;
    chk("rnd_in_time", 32'(cyc < 4000), 1);
    chk("rnd_sent", 32'(sent), 200);
    chk("rnd_count", 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk("rnd_word", 32'(obs[i]), 32'(exp_q[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
